// File: rtl/conv_col_filter_if.sv
// Column/kernel input bus and result bus of the streaming convolution filter.
// master = column feeder side, slave = filter side.
// No backpressure: the feeder may present a column every cycle.
interface conv_col_filter_if #(
   parameter int DATA_WIDTH     = 16,
   parameter int KERNEL_SIZE    = 3,
   parameter int INPUT_COL_SIZE = 12,
   parameter int IMG_WIDTH      = 12
);
   localparam int OUT_ROWS = INPUT_COL_SIZE - KERNEL_SIZE + 1;
   localparam int IDX_W    = $clog2(IMG_WIDTH);

   logic                                       kernel_load;
   logic                                       valid_in;
   logic                                       stride_sel;
   logic [INPUT_COL_SIZE-1:0][DATA_WIDTH-1:0]  input_column;
   logic [KERNEL_SIZE-1:0][DATA_WIDTH-1:0]     kernel_column;
   logic                                       kernel_ready;
   logic                                       out_valid;
   logic [OUT_ROWS-1:0][DATA_WIDTH-1:0]        out_column;
   logic [IDX_W-1:0]                           out_col_idx;
   logic                                       frame_done;
   logic                                       err_no_kernel;

   modport master (
      output kernel_load, valid_in, stride_sel, input_column, kernel_column,
      input  kernel_ready, out_valid, out_column, out_col_idx, frame_done, err_no_kernel
   );

   modport slave (
      input  kernel_load, valid_in, stride_sel, input_column, kernel_column,
      output kernel_ready, out_valid, out_column, out_col_idx, frame_done, err_no_kernel
   );
endinterface

// File: rtl/conv_col_filter.sv
// Streaming KxK convolution over a sliding window of image columns; one result column per window.
// Latency: trigger column accepted at edge t -> out_valid after edge t+3 (window, product, sum, reduce).
// No backpressure; optional output saturation enabled by defining CONV_SAT_EN (default wraps).
module conv_col_filter #(
   parameter int DATA_WIDTH     = 16,
   parameter int FRAC_BITS      = 14,
   parameter int KERNEL_SIZE    = 3,
   parameter int INPUT_COL_SIZE = 12,
   parameter int IMG_WIDTH      = 12
) (
   input logic             clk,
   input logic             rst,
   conv_col_filter_if.slave io
);
   localparam int K        = KERNEL_SIZE;
   localparam int DW       = DATA_WIDTH;
   localparam int OUT_ROWS = INPUT_COL_SIZE - K + 1;
   localparam int IDX_W    = $clog2(IMG_WIDTH);
   localparam int KW       = $clog2(K);
   localparam int PROD_W   = 2 * DW;
   localparam int SUM_W    = 2 * DW + $clog2(K * K);

   typedef logic signed [PROD_W-1:0] prod_t;
   typedef logic signed [SUM_W-1:0]  sum_t;
   typedef logic [INPUT_COL_SIZE-1:0][DW-1:0] col_t;
   typedef logic [K-1:0][DW-1:0]              kcol_t;

`ifdef CONV_SAT_EN
   localparam sum_t MAX_V = sum_t'({1'b0, {(DW-1){1'b1}}});
   localparam sum_t MIN_V = ~MAX_V;
`endif

   // kernel store: slot 0 pairs with the oldest window column
   kcol_t             kern [K];
   logic [KW-1:0]     kidx;
   logic              kernel_ready_q;
   logic              err_q;

   // window: win[0] oldest, win[K-1] newest
   col_t              win [K];
   logic [IDX_W-1:0]  col_cnt;
   logic [IDX_W-1:0]  out_idx;
   logic              stride2;

   // pipeline valid/tag registers
   logic              v0, v1, v2;
   logic              last0, last1, last2;
   logic [IDX_W-1:0]  idx0, idx1, idx2;

   prod_t             prod [OUT_ROWS][K][K];
   sum_t              sum_d [OUT_ROWS];
   sum_t              sum_q [OUT_ROWS];
   logic [OUT_ROWS-1:0][DW-1:0] res;

   logic              accept;
   logic              trigger;
   logic              last_out;
   logic [IDX_W-1:0]  rel;

   // accept/trigger decode for the column presented this cycle
   always_comb begin
      accept   = io.valid_in && !io.kernel_load && kernel_ready_q;
      rel      = col_cnt - IDX_W'(K - 1);
      trigger  = accept && (col_cnt >= IDX_W'(K - 1)) && (!stride2 || !rel[0]);
      last_out = stride2 ? (col_cnt >= IDX_W'(IMG_WIDTH - 2))
                         : (col_cnt == IDX_W'(IMG_WIDTH - 1));
   end

   // kernel load, frame tracking, window shift and stage-0 tags
   // (a frame restart only rewinds col_cnt: no trigger fires until K fresh columns arrive)
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int s = 0; s < K; s++) kern[s] <= '0;
         for (int s = 0; s < K; s++) win[s]  <= '0;
         kidx           <= '0;
         kernel_ready_q <= 1'b0;
         err_q          <= 1'b0;
         col_cnt        <= '0;
         out_idx        <= '0;
         stride2        <= 1'b0;
         v0             <= 1'b0;
         last0          <= 1'b0;
         idx0           <= '0;
      end else begin
         v0    <= trigger;
         last0 <= trigger && last_out;
         idx0  <= out_idx;
         if (io.valid_in && !io.kernel_load && !kernel_ready_q) err_q <= 1'b1;
         if (io.kernel_load && io.valid_in) begin
            kern[kidx] <= io.kernel_column;
            if (kidx == KW'(K - 1)) begin
               kidx           <= '0;
               kernel_ready_q <= 1'b1;
            end else begin
               kidx <= kidx + KW'(1);
            end
         end
         if (io.kernel_load) begin
            col_cnt <= '0;
            out_idx <= '0;
         end else if (accept) begin
            for (int j = 0; j < K - 1; j++) win[j] <= win[j+1];
            win[K-1] <= io.input_column;
            col_cnt  <= (col_cnt == IDX_W'(IMG_WIDTH - 1)) ? '0 : col_cnt + IDX_W'(1);
            if (col_cnt == '0) stride2 <= io.stride_sel;
            if (trigger) out_idx <= last_out ? '0 : out_idx + IDX_W'(1);
         end
      end
   end

   // stage 1: all K*K products for every output row
   always_ff @(posedge clk) begin
      for (int o = 0; o < OUT_ROWS; o++)
         for (int c = 0; c < K; c++)
            for (int r = 0; r < K; r++)
               prod[o][c][r] <= prod_t'($signed(win[c][o+r])) * prod_t'($signed(kern[c][r]));
   end

   // stage 2 input: full-precision sum of each row's products
   always_comb begin
      for (int o = 0; o < OUT_ROWS; o++) begin
         sum_d[o] = '0;
         for (int c = 0; c < K; c++)
            for (int r = 0; r < K; r++)
               sum_d[o] = sum_d[o] + sum_t'(prod[o][c][r]);
      end
   end

   // stage 2: register sums
   always_ff @(posedge clk) begin
      for (int o = 0; o < OUT_ROWS; o++) sum_q[o] <= sum_d[o];
   end

   // stage 3 input: drop fraction bits (floor) and reduce to DW
   always_comb begin
      res = '0;
      for (int o = 0; o < OUT_ROWS; o++) begin
`ifdef CONV_SAT_EN
         if ((sum_q[o] >>> FRAC_BITS) > MAX_V)      res[o] = MAX_V[DW-1:0];
         else if ((sum_q[o] >>> FRAC_BITS) < MIN_V) res[o] = MIN_V[DW-1:0];
         else                                       res[o] = DW'(sum_q[o] >>> FRAC_BITS);
`else
         res[o] = DW'(sum_q[o] >>> FRAC_BITS);
`endif
      end
   end

   // pipeline valids/tags and output registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         v1             <= 1'b0;
         v2             <= 1'b0;
         last1          <= 1'b0;
         last2          <= 1'b0;
         idx1           <= '0;
         idx2           <= '0;
         io.out_valid   <= 1'b0;
         io.frame_done  <= 1'b0;
         io.out_column  <= '0;
         io.out_col_idx <= '0;
      end else begin
         v1            <= v0;
         v2            <= v1;
         last1         <= last0;
         last2         <= last1;
         idx1          <= idx0;
         idx2          <= idx1;
         io.out_valid  <= v2;
         io.frame_done <= v2 && last2;
         if (v2) begin
            io.out_column  <= res;
            io.out_col_idx <= idx2;
         end
      end
   end

   assign io.kernel_ready  = kernel_ready_q;
   assign io.err_no_kernel = err_q;
endmodule

// File: tb/tb_conv_col_filter.sv
// Directed bench for conv_col_filter: ramp/stride/abort/reset sequences plus an arithmetic table.
module tb_conv_col_filter;
   localparam int DW       = 16;
   localparam int K        = 3;
   localparam int ROWS     = 12;
   localparam int W        = 12;
   localparam int OUT_ROWS = ROWS - K + 1;

   typedef logic [ROWS-1:0][DW-1:0]     colin_t;
   typedef logic [OUT_ROWS-1:0][DW-1:0] colout_t;
   typedef logic [K-1:0][K-1:0][DW-1:0] kmat_t;   // [slot][row]

   typedef struct {
      int      cyc;
      int      idx;
      logic    fd;
      colout_t col;
   } out_rec_t;

   typedef struct {
      string          name;
      logic [DW-1:0]  k;
      logic [DW-1:0]  x;
      logic [DW-1:0]  exp;
   } vec_t;

`ifdef CONV_SAT_EN
   localparam logic [DW-1:0] EXP_POS_OVF = 16'h7FFF;
`else
   localparam logic [DW-1:0] EXP_POS_OVF = 16'h7FF7;
`endif

   logic clk = 1'b0;
   logic rst;
   int   cyc = 0;
   int   checks = 0;
   int   failures = 0;
   out_rec_t outq[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   conv_col_filter_if #(.DATA_WIDTH(DW), .KERNEL_SIZE(K), .INPUT_COL_SIZE(ROWS), .IMG_WIDTH(W)) bus ();

   conv_col_filter #(.DATA_WIDTH(DW), .FRAC_BITS(14), .KERNEL_SIZE(K),
                     .INPUT_COL_SIZE(ROWS), .IMG_WIDTH(W)) dut (
      .clk (clk),
      .rst (rst),
      .io  (bus)
   );

   always @(negedge clk) begin
      if (bus.out_valid)
         outq.push_back('{cyc, int'(bus.out_col_idx), bus.frame_done, bus.out_column});
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic load_kernel(input kmat_t km);
      for (int s = 0; s < K; s++) begin
         bus.kernel_load   = 1'b1;
         bus.valid_in      = 1'b1;
         bus.kernel_column = km[s];
         step();
      end
      bus.kernel_load = 1'b0;
      bus.valid_in    = 1'b0;
   endtask

   function automatic colin_t ramp(input int base, input int c);
      colin_t v;
      for (int r = 0; r < ROWS; r++) v[r] = DW'(base + 16 * c + r);
      return v;
   endfunction

   // back-to-back ramp columns; returns the cycle stamp of the accept edge of column K-1
   task automatic send_frame(input int base, input int ncols, input logic s_first,
                             input logic s_rest, output int trig_cyc);
      trig_cyc = -1;
      for (int c = 0; c < ncols; c++) begin
         bus.kernel_load  = 1'b0;
         bus.valid_in     = 1'b1;
         bus.stride_sel   = (c == 0) ? s_first : s_rest;
         bus.input_column = ramp(base, c);
         step();
         if (c == K - 1) trig_cyc = cyc;
      end
      bus.valid_in = 1'b0;
   endtask

   function automatic colout_t exp_mid(input int base, input int mid_col);
      colout_t v;
      for (int i = 0; i < OUT_ROWS; i++) v[i] = DW'(base + 16 * mid_col + i + 1);
      return v;
   endfunction

   function automatic colout_t exp_old(input int base, input int old_col);
      colout_t v;
      for (int i = 0; i < OUT_ROWS; i++) v[i] = DW'(base + 16 * old_col + i);
      return v;
   endfunction

   initial begin
      kmat_t  kid;
      kmat_t  kold;
      kmat_t  kfill;
      colin_t cfill;
      colout_t ofill;
      vec_t   vecs[7];
      int     tc;
      int     n;

      vecs[0] = '{"sat_pos",   16'h4000, 16'h7FFF, EXP_POS_OVF};
      vecs[1] = '{"sat_neg",   16'h4000, 16'h8000, 16'h8000};
      vecs[2] = '{"quarter",   16'h1000, 16'h0100, 16'h0240};
      vecs[3] = '{"neg_floor", 16'hF000, 16'h0003, 16'hFFF9};
      vecs[4] = '{"tiny_pos",  16'h0001, 16'h0001, 16'h0000};
      vecs[5] = '{"tiny_neg",  16'hFFFF, 16'h0001, 16'hFFFF};
      vecs[6] = '{"half",      16'h2000, 16'h1000, 16'h4800};

      kid  = '0;
      kid[1][1] = 16'h4000;
      kold = '0;
      kold[0][0] = 16'h4000;

      rst               = 1'b1;
      bus.kernel_load   = 1'b0;
      bus.valid_in      = 1'b0;
      bus.stride_sel    = 1'b0;
      bus.input_column  = '0;
      bus.kernel_column = '0;
      idle(3);
      rst = 1'b0;
      step();

      // reset state
      check("rst_kernel_ready", bus.kernel_ready, 1'b0);
      check("rst_out_valid",    bus.out_valid, 1'b0);
      check("rst_out_column",   bus.out_column, '0);
      check("rst_out_col_idx",  bus.out_col_idx, '0);
      check("rst_frame_done",   bus.frame_done, 1'b0);
      check("rst_err",          bus.err_no_kernel, 1'b0);

      // columns before any kernel: dropped, sticky error
      outq.delete();
      send_frame(0, 2, 1'b0, 1'b0, tc);
      idle(6);
      check("nokern_outputs", outq.size(), 0);
      check("nokern_err", bus.err_no_kernel, 1'b1);
      load_kernel(kid);
      check("load_ready", bus.kernel_ready, 1'b1);
      check("load_err_sticky", bus.err_no_kernel, 1'b1);

      // identity kernel, stride 1
      outq.delete();
      send_frame(0, W, 1'b0, 1'b0, tc);
      idle(6);
      check("s1_count", outq.size(), W - K + 1);
      n = (outq.size() < W - K + 1) ? outq.size() : W - K + 1;
      if (n > 0) begin
         check("s1_latency", outq[0].cyc - tc, 3);
         check("s1_throughput", outq[n-1].cyc - outq[0].cyc, n - 1);
      end
      for (int j = 0; j < n; j++) begin
         check($sformatf("s1_idx%0d", j), outq[j].idx, j);
         check($sformatf("s1_fd%0d", j),  outq[j].fd, j == W - K);
         check($sformatf("s1_col%0d", j), outq[j].col, exp_mid(0, j + 1));
      end

      // stride 2 sampled at frame start; mid-frame change ignored
      outq.delete();
      send_frame(0, W, 1'b1, 1'b0, tc);
      idle(6);
      check("s2_count", outq.size(), 5);
      n = (outq.size() < 5) ? outq.size() : 5;
      for (int j = 0; j < n; j++) begin
         check($sformatf("s2_idx%0d", j), outq[j].idx, j);
         check($sformatf("s2_fd%0d", j),  outq[j].fd, j == 4);
         check($sformatf("s2_col%0d", j), outq[j].col, exp_mid(0, 2 * j + 1));
      end

      // abort after column 6 by reloading a kernel that picks the oldest column
      outq.delete();
      send_frame(0, 7, 1'b0, 1'b0, tc);
      load_kernel(kold);
      send_frame(16'h200, W, 1'b0, 1'b0, tc);
      idle(6);
      check("abort_count", outq.size(), 5 + W - K + 1);
      n = (outq.size() < 5 + W - K + 1) ? outq.size() : 5 + W - K + 1;
      for (int j = 0; j < n; j++) begin
         if (j < 5) begin
            check($sformatf("abort_old_idx%0d", j), outq[j].idx, j);
            check($sformatf("abort_old_fd%0d", j),  outq[j].fd, 1'b0);
            check($sformatf("abort_old_col%0d", j), outq[j].col, exp_mid(0, j + 1));
         end else begin
            check($sformatf("abort_new_idx%0d", j - 5), outq[j].idx, j - 5);
            check($sformatf("abort_new_fd%0d", j - 5),  outq[j].fd, (j - 5) == W - K);
            check($sformatf("abort_new_col%0d", j - 5), outq[j].col, exp_old(16'h200, j - 5));
         end
      end

      // arithmetic table: uniform kernel and uniform columns
      for (int v = 0; v < 7; v++) begin
         for (int s = 0; s < K; s++)
            for (int r = 0; r < K; r++) kfill[s][r] = vecs[v].k;
         for (int r = 0; r < ROWS; r++) cfill[r] = vecs[v].x;
         for (int i = 0; i < OUT_ROWS; i++) ofill[i] = vecs[v].exp;
         load_kernel(kfill);
         outq.delete();
         for (int c = 0; c < K; c++) begin
            bus.valid_in     = 1'b1;
            bus.stride_sel   = 1'b0;
            bus.input_column = cfill;
            step();
         end
         bus.valid_in = 1'b0;
         idle(6);
         check({vecs[v].name, "_count"}, outq.size(), 1);
         if (outq.size() > 0) check({vecs[v].name, "_col"}, outq[0].col, ofill);
      end

      // reset one cycle after a trigger column kills the in-flight result
      load_kernel(kid);
      outq.delete();
      send_frame(0, K, 1'b0, 1'b0, tc);
      step();
      rst = 1'b1;
      idle(2);
      rst = 1'b0;
      idle(6);
      check("rstmid_outputs", outq.size(), 0);
      check("rstmid_out_valid", bus.out_valid, 1'b0);
      check("rstmid_out_column", bus.out_column, '0);
      check("rstmid_out_col_idx", bus.out_col_idx, '0);
      check("rstmid_frame_done", bus.frame_done, 1'b0);
      check("rstmid_kernel_ready", bus.kernel_ready, 1'b0);
      check("rstmid_err", bus.err_no_kernel, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
